uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, downstream of the ARM core. It decodes the core's `data_memory_addr` / `mem_write` / `write_data` for its own address window and queues written bytes in a small FIFO. It serialises them as 8N1 frames on `tx` and returns status words through `rd_data`. The top level uses `sel` to choose between `rd_data` and data-memory read data before driving the core's `read_data`.

## Interface

Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: 16-byte window base; `[3:0]` must be 0.
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 4: byte entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_write` in 1: core store strobe.
- `data_memory_addr` in 32: core data address.
- `write_data` in 32: core store data.
- `sel` out 1: combinational; 1 when `data_memory_addr[31:4] == BASE_ADDR[31:4]`, independent of `mem_write`.
- `rd_data` out 32: combinational read data for the decoded offset.
- `tx` out 1: registered serial output; idle high.
- `busy` out 1: registered; 1 while state ≠ IDLE.

## Operation

- Register map, word offset `addr[3:2]`:
  - 0 TXDATA: write pushes `write_data[7:0]`; reads as 0.
  - 1 STATUS: read only; any write clears `overflow`.
    - bit0 `busy`, bit1 `full`, bit2 `empty`, bit3 `overflow` (sticky), bits[15:8] FIFO `count`, all other bits 0.
  - 2, 3: reserved; reads 0, writes ignored.
- Byte lanes and `addr[1:0]` are ignored.
- Push occurs on the edge where `mem_write & sel & offset==0`.
  - If the pre-edge count equals `FIFO_DEPTH`, the byte is dropped and `overflow` is set. This holds even when a pop occurs on the same edge.
  - Otherwise the push is accepted. A push and a pop on the same edge leave `count` unchanged.
- `count` width is `$clog2(FIFO_DEPTH+1)`. Read and write pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP. A down-counter `baud_cnt` is loaded with `CLKS_PER_BIT-1` on each bit entry; `bit_idx` runs 0..7.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into `shreg` and go to START.
  - START: `tx`=0. When `baud_cnt`==0, go to DATA with `bit_idx`=0.
  - DATA: `tx`=`shreg[bit_idx]` (LSB first). When `baud_cnt`==0, increment `bit_idx`; after bit 7, go to STOP.
  - STOP: `tx`=1. When `baud_cnt`==0: if the FIFO is non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- Reset, including mid-frame:
  - Values after the reset edge: state IDLE, `tx`=1, `busy`=0, FIFO flushed (pointers and count 0), `overflow`=0, `baud_cnt`=0, `bit_idx`=0, `shreg`=0.
  - Writes on a reset cycle are ignored.

## Timing

- `sel` and `rd_data` are purely combinational from the address and current registers (single-cycle core load path).
- Write captured at edge N:
  - `count` and `empty` update visibly after N.
  - If IDLE, the pop occurs at N+1 and `tx` falls low after N+1. `busy` rises after N+1.
- Each bit holds for exactly `CLKS_PER_BIT` cycles. A frame is `10*CLKS_PER_BIT` cycles.
- Back-to-back frames have zero gap: the STOP→START transition is a single edge.
- STATUS read in the same cycle as a TXDATA write returns pre-edge values.

## Test plan

Bench parameters: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, `BASE_ADDR`=32'hFFFF_0000.

- Reset, then read 0xFFFF0004 → `rd_data`=0x00000004, `sel`=1, `tx`=1, `busy`=0.
- Write 0x55 to 0xFFFF0000 → starting one cycle later, `tx` shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `busy`=1 for 40 cycles, then 0; final STATUS=0x00000004.
- Write 0x41..0x46 on 6 consecutive cycles → bytes 0x41..0x45 are transmitted back-to-back (200 cycles, `tx` never idles between frames) and 0x46 is dropped. STATUS bit3=1 immediately after the 6th write.
- After overflow, write any value to 0xFFFF0004 → bit3 clears next cycle; `count` is unaffected.
- Write 0x0F, then assert `reset` mid-DATA (cycle 15) → `tx`=1, `busy`=0 and STATUS=0x00000004 after the reset edge, with no further frame output.
- Write 0xAA to 0xFFFE0000, and read 0xFFFF0008 → `sel`=0 on the first; no frame is sent; the second gives `rd_data`=0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window on the core data bus
// feeding a small byte FIFO that drains into a serialiser with back-to-back framing.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_memory_addr,
    input  logic [31:0] write_data,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      next_idx;
    logic [7:0]      shreg;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic [1:0]      offset;
    logic            push_req;
    logic            push_ok;
    logic            clr_ovf;
    logic            full;
    logic            empty;
    logic            pop;
    logic            unused_bits;

    assign offset   = data_memory_addr[3:2];
    assign sel      = (data_memory_addr[31:4] == BASE_ADDR[31:4]);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = mem_write & sel & (offset == 2'd0);
    assign push_ok  = push_req & ~full & ~reset;
    assign clr_ovf  = mem_write & sel & (offset == 2'd1);
    assign next_idx = bit_idx + 3'd1;

    // The serialiser takes a byte either from idle or straight out of the stop bit.
    assign pop = ~empty & ((state == IDLE) | ((state == STOP) & (baud_cnt == '0)));

    assign unused_bits = ^{write_data[31:8], data_memory_addr[1:0]};

    always_comb begin
        rd_data = '0;
        if (offset == 2'd1) begin
            rd_data = {16'd0, 8'(count), 4'd0, overflow, empty, full, busy};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A full FIFO drops the byte even if a pop frees a slot on the same edge.
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= BAUD_LOAD;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        baud_cnt <= BAUD_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= shreg[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (pop) begin
                            shreg    <= mem[rd_ptr];
                            state    <= START;
                            tx       <= 1'b0;
                            baud_cnt <= BAUD_LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
